// File: rtl/atm_keypad_entry_if.sv
// Keypad-entry bus: key strokes in, one assembled ATM transaction request out.
// master = the keypad entry block, slave = the keypad source and the ATM core.
interface atm_keypad_entry_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        req_ready;
    logic        req_valid;
    logic [3:0]  acc_num;
    logic [15:0] pin;
    logic [2:0]  operation;
    logic [31:0] amount;
    logic [15:0] newPin;
    logic [2:0]  entry_state;
    logic [3:0]  digit_cnt;
    logic        key_err;
    logic        timeout;

    modport master (
        input  key_valid, key_code, req_ready,
        output req_valid, acc_num, pin, operation, amount, newPin,
               entry_state, digit_cnt, key_err, timeout
    );

    modport slave (
        output key_valid, key_code, req_ready,
        input  req_valid, acc_num, pin, operation, amount, newPin,
               entry_state, digit_cnt, key_err, timeout
    );
endinterface

// File: rtl/atm_keypad_entry.sv
// Keypad front end: assembles account/PIN/op/amount/new-PIN into one ATM request.
// Optional inactivity abort is enabled with macro KEYPAD_TIMEOUT_EN.
module atm_keypad_entry #(
    parameter int unsigned AMT_DIGITS  = 9,
    parameter int unsigned OP_WITHDRAW = 4,
    parameter int unsigned OP_DEPOSIT  = 5,
    parameter int unsigned OP_CHPIN    = 2
`ifdef KEYPAD_TIMEOUT_EN
   ,parameter int unsigned TIMEOUT_CYCLES = 1000000
`endif
) (
    input logic                clk,
    input logic                rst,
    atm_keypad_entry_if.master kp
);

    localparam int unsigned ACC_W  = 32;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned PIN_W  = 16;
    localparam int unsigned NUM_W  = 4;
    localparam int unsigned OP_W   = 3;

    localparam logic [3:0] K_CLEAR  = 4'hA;
    localparam logic [3:0] K_ENTER  = 4'hB;
    localparam logic [3:0] K_CANCEL = 4'hC;

    typedef enum logic [2:0] {
        S_ACC   = 3'd0,
        S_PIN   = 3'd1,
        S_OP    = 3'd2,
        S_AMT   = 3'd3,
        S_NPIN  = 3'd4,
        S_ISSUE = 3'd5
    } state_t;

    state_t             state, state_nxt, adv_state_c;
    logic [ACC_W-1:0]   acc, acc_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt, limit_c;
    logic               is_digit_c, enter_ok_c, err_c, clr_all_c, latch_c;

    logic               req_valid_q, key_err_q;
    logic [NUM_W-1:0]   acc_num_q;
    logic [PIN_W-1:0]   pin_q, npin_q;
    logic [OP_W-1:0]    op_q;
    logic [ACC_W-1:0]   amount_q;

`ifdef KEYPAD_TIMEOUT_EN
    localparam int unsigned IDLE_W = 20;
    logic [IDLE_W-1:0]  idle;
    logic               idle_run_c, tmo_c, timeout_q;
`endif

    assign is_digit_c = (kp.key_code <= 4'd9);

    // Maximum digits accepted by the field currently being typed
    always_comb begin
        limit_c = '0;
        case (state)
            S_ACC:   limit_c = CNT_W'(2);
            S_PIN:   limit_c = CNT_W'(4);
            S_OP:    limit_c = CNT_W'(1);
            S_AMT:   limit_c = CNT_W'(AMT_DIGITS);
            S_NPIN:  limit_c = CNT_W'(4);
            default: limit_c = '0;
        endcase
    end

    // ENTER acceptance for the current field and where it leads
    always_comb begin
        enter_ok_c  = 1'b0;
        adv_state_c = state;
        case (state)
            S_ACC: begin
                enter_ok_c  = (cnt != '0) && (acc >= ACC_W'(1)) && (acc <= ACC_W'(10));
                adv_state_c = S_PIN;
            end
            S_PIN: begin
                enter_ok_c  = (cnt == CNT_W'(4));
                adv_state_c = S_OP;
            end
            S_OP: begin
                enter_ok_c = (cnt == CNT_W'(1)) && (acc <= ACC_W'(7));
                if ((acc == ACC_W'(OP_WITHDRAW)) || (acc == ACC_W'(OP_DEPOSIT)))
                    adv_state_c = S_AMT;
                else if (acc == ACC_W'(OP_CHPIN))
                    adv_state_c = S_NPIN;
                else
                    adv_state_c = S_ISSUE;
            end
            S_AMT: begin
                enter_ok_c  = (cnt != '0) && (acc != '0);
                adv_state_c = S_ISSUE;
            end
            S_NPIN: begin
                enter_ok_c  = (cnt == CNT_W'(4));
                adv_state_c = S_ISSUE;
            end
            default: ;
        endcase
    end

`ifdef KEYPAD_TIMEOUT_EN
    assign idle_run_c = (state == S_PIN) || (state == S_OP) ||
                        (state == S_AMT) || (state == S_NPIN);
`endif

    // Key decode and next-state selection
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        err_c     = 1'b0;
        clr_all_c = 1'b0;
        latch_c   = 1'b0;
`ifdef KEYPAD_TIMEOUT_EN
        tmo_c     = 1'b0;
`endif
        case (state)
            S_ISSUE: begin
                // Request is committed: only the handshake releases it
                if (req_valid_q && kp.req_ready)
                    clr_all_c = 1'b1;
            end
            S_ACC, S_PIN, S_OP, S_AMT, S_NPIN: begin
                if (kp.key_valid) begin
                    if (is_digit_c) begin
                        if (cnt < limit_c) begin
                            acc_nxt = acc * ACC_W'(10) + ACC_W'(kp.key_code);
                            cnt_nxt = cnt + CNT_W'(1);
                        end else begin
                            err_c = 1'b1;
                        end
                    end else begin
                        case (kp.key_code)
                            K_CLEAR: begin
                                acc_nxt = '0;
                                cnt_nxt = '0;
                            end
                            K_CANCEL: clr_all_c = 1'b1;
                            K_ENTER: begin
                                if (enter_ok_c) begin
                                    latch_c   = 1'b1;
                                    acc_nxt   = '0;
                                    cnt_nxt   = '0;
                                    state_nxt = adv_state_c;
                                end else begin
                                    err_c = 1'b1;
                                    // A rejected account number is wiped for re-entry
                                    if (state == S_ACC) begin
                                        acc_nxt = '0;
                                        cnt_nxt = '0;
                                    end
                                end
                            end
                            default: err_c = 1'b1;
                        endcase
                    end
                end
`ifdef KEYPAD_TIMEOUT_EN
                else if (idle_run_c && (idle == IDLE_W'(1))) begin
                    tmo_c     = 1'b1;
                    clr_all_c = 1'b1;
                end
`endif
            end
            default: clr_all_c = 1'b1;
        endcase

        if (clr_all_c) begin
            state_nxt = S_ACC;
            acc_nxt   = '0;
            cnt_nxt   = '0;
        end
    end

    // State, accumulator and registered request fields
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_ACC;
            acc         <= '0;
            cnt         <= '0;
            req_valid_q <= 1'b0;
            key_err_q   <= 1'b0;
            acc_num_q   <= '0;
            pin_q       <= '0;
            op_q        <= '0;
            amount_q    <= '0;
            npin_q      <= '0;
        end else begin
            state       <= state_nxt;
            acc         <= acc_nxt;
            cnt         <= cnt_nxt;
            key_err_q   <= err_c;
            req_valid_q <= (state_nxt == S_ISSUE);
            if (clr_all_c) begin
                acc_num_q <= '0;
                pin_q     <= '0;
                op_q      <= '0;
                amount_q  <= '0;
                npin_q    <= '0;
            end else if (latch_c) begin
                case (state)
                    S_ACC:   acc_num_q <= acc[NUM_W-1:0];
                    S_PIN:   pin_q     <= acc[PIN_W-1:0];
                    S_OP:    op_q      <= acc[OP_W-1:0];
                    S_AMT:   amount_q  <= acc;
                    S_NPIN:  npin_q    <= acc[PIN_W-1:0];
                    default: ;
                endcase
            end
        end
    end

`ifdef KEYPAD_TIMEOUT_EN
    // Idle counter: reloads on any key, runs only while a session is mid-entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle      <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= tmo_c;
            if (kp.key_valid)
                idle <= IDLE_W'(TIMEOUT_CYCLES);
            else if (idle_run_c && (idle != '0))
                idle <= idle - IDLE_W'(1);
        end
    end

    assign kp.timeout = timeout_q;
`else
    assign kp.timeout = 1'b0;
`endif

    assign kp.req_valid   = req_valid_q;
    assign kp.acc_num     = acc_num_q;
    assign kp.pin         = pin_q;
    assign kp.operation   = op_q;
    assign kp.amount      = amount_q;
    assign kp.newPin      = npin_q;
    assign kp.entry_state = state;
    assign kp.digit_cnt   = cnt;
    assign kp.key_err     = key_err_q;

endmodule

// File: tb/tb_atm_keypad_entry.sv
// Scoreboard bench for atm_keypad_entry: directed test-plan sequences, then random sessions,
// all predicted by a digit-queue model of the keypad rules.
module tb_atm_keypad_entry;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    atm_keypad_entry_if kp();

    atm_keypad_entry dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp)
    );

    typedef struct {
        bit err;
        int st;
        int cnt;
        bit rv;
    } stat_t;

    typedef struct {
        int     acc;
        int     pin;
        int     op;
        longint amt;
        int     npin;
    } req_t;

    stat_t st_q[$];
    req_t  rq_q[$];
    int    vectors     = 0;
    int    miscompares = 0;

    // Model: current field as a queue of typed digits plus the latched fields
    int    m_st;
    int    m_dig[$];
    req_t  m_req;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lim(input int s);
        case (s)
            0: return 2;
            1: return 4;
            2: return 1;
            3: return 9;
            4: return 4;
            default: return 0;
        endcase
    endfunction

    function automatic longint field_value();
        longint v = 0;
        foreach (m_dig[i]) v = v * 10 + m_dig[i];
        return v;
    endfunction

    task automatic clear_model();
        m_st = 0;
        m_dig.delete();
        m_req = '{acc: 0, pin: 0, op: 0, amt: 0, npin: 0};
    endtask

    task automatic enter_model(output bit err);
        longint v  = field_value();
        int     n  = m_dig.size();
        bit     ok = 0;
        int     nx = m_st;
        err = 0;
        case (m_st)
            0: begin ok = (n > 0) && (v >= 1) && (v <= 10); nx = 1; if (ok) m_req.acc = int'(v); end
            1: begin ok = (n == 4); nx = 2; if (ok) m_req.pin = int'(v); end
            2: begin
                ok = (n == 1) && (v <= 7);
                if (ok) m_req.op = int'(v);
                nx = (v == 4 || v == 5) ? 3 : (v == 2) ? 4 : 5;
            end
            3: begin ok = (n >= 1) && (v != 0); nx = 5; if (ok) m_req.amt = v; end
            4: begin ok = (n == 4); nx = 5; if (ok) m_req.npin = int'(v); end
            default: ok = 0;
        endcase
        if (ok) begin
            m_dig.delete();
            m_st = nx;
            if (nx == 5) rq_q.push_back(m_req);
        end else begin
            err = 1;
            if (m_st == 0) m_dig.delete();
        end
    endtask

    task automatic model_step(input bit kv, input int code, input bit rdy);
        stat_t s;
        bit    err = 0;
        if (m_st == 5) begin
            if (rdy) clear_model();
        end else if (kv) begin
            if (code <= 9) begin
                if (m_dig.size() < lim(m_st)) m_dig.push_back(code);
                else err = 1;
            end else if (code == 10) m_dig.delete();
            else if (code == 12) clear_model();
            else if (code == 11) enter_model(err);
            else err = 1;
        end
        s.err = err;
        s.st  = m_st;
        s.cnt = m_dig.size();
        s.rv  = (m_st == 5);
        st_q.push_back(s);
    endtask

    // One clock of stimulus; expectation for the following edge goes to the scoreboard
    task automatic step(input bit kv, input int code, input bit rdy);
        @(negedge clk);
        kp.key_valid = kv;
        kp.key_code  = 4'(code);
        kp.req_ready = rdy;
        model_step(kv, code, rdy);
    endtask

    task automatic send_seq(input int s[$]);
        foreach (s[i]) begin
            step(1'b1, s[i], 1'b0);
            step(1'b0, 0, 1'b0);
        end
    endtask

    task automatic hold(input int n, input bit rdy);
        repeat (n) step(1'b0, 0, rdy);
    endtask

    task automatic noise();
        int r = $urandom_range(0, 99);
        if (r < 5)       step(1'b1, 10, 1'b0);
        else if (r < 8)  step(1'b1, $urandom_range(13, 15), 1'b0);
        else if (r < 10) step(1'b1, 12, 1'b0);
    endtask

    task automatic send_digits(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, $urandom_range(0, 9), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) step(1'b0, 0, 1'b0);
        end
    endtask

    task automatic rand_txn();
        int v, op, r;
        v = $urandom_range(0, 12);
        noise();
        if (v >= 10) step(1'b1, v / 10, 1'b0);
        step(1'b1, v % 10, 1'b0);
        step(1'b1, 11, 1'b0);
        noise();
        r = $urandom_range(0, 9);
        send_digits(r == 0 ? 3 : r == 1 ? 5 : 4);
        step(1'b1, 11, 1'b0);
        r  = $urandom_range(0, 9);
        op = (r < 3) ? 4 : (r < 5) ? 5 : (r < 7) ? 2 : $urandom_range(0, 9);
        step(1'b1, op, 1'b0);
        step(1'b1, 11, 1'b0);
        noise();
        if (op == 4 || op == 5) begin
            r = $urandom_range(0, 9);
            send_digits(r == 0 ? 10 : $urandom_range(1, 9));
            step(1'b1, 11, 1'b0);
        end else if (op == 2) begin
            send_digits($urandom_range(0, 5) == 0 ? 3 : 4);
            step(1'b1, 11, 1'b0);
        end
        for (int i = 0; i < 40 && m_st == 5; i++)
            step(1'($urandom_range(0, 3) == 0), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
        if (m_st == 5) step(1'b0, 0, 1'b1);
        if (m_st != 0) step(1'b1, 12, 1'b0);
        hold(1, 1'b0);
    endtask

    // Monitor: compares status every cycle and the request whenever req_valid is high
    initial begin
        stat_t e;
        bit    prev_rv = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (st_q.size() > 0) begin
                e = st_q.pop_front();
                check("key_err", kp.key_err, e.err);
                check("entry_state", kp.entry_state, e.st);
                check("digit_cnt", kp.digit_cnt, e.cnt);
                check("req_valid", kp.req_valid, e.rv);
                check("timeout", kp.timeout, 0);
                if (kp.req_valid === 1'b1) begin
                    if (rq_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL req_unexpected: got req_valid 1 expected no pending request at %0t", $time);
                    end else begin
                        check("acc_num", kp.acc_num, rq_q[0].acc);
                        check("pin", kp.pin, rq_q[0].pin);
                        check("operation", kp.operation, rq_q[0].op);
                        check("amount", kp.amount, rq_q[0].amt);
                        check("newPin", kp.newPin, rq_q[0].npin);
                    end
                end
                if (prev_rv && kp.req_valid !== 1'b1 && rq_q.size() > 0)
                    void'(rq_q.pop_front());
                prev_rv = (kp.req_valid === 1'b1);
            end
        end
    end

    initial begin
        int seq[$];
        rst          = 1'b0;
        kp.key_valid = 1'b0;
        kp.key_code  = '0;
        kp.req_ready = 1'b0;
        clear_model();
        repeat (3) @(negedge clk);
        check("rst_entry_state", kp.entry_state, 0);
        check("rst_req_valid", kp.req_valid, 0);
        check("rst_acc_num", kp.acc_num, 0);
        check("rst_pin", kp.pin, 0);
        check("rst_operation", kp.operation, 0);
        check("rst_amount", kp.amount, 0);
        check("rst_newPin", kp.newPin, 0);
        check("rst_digit_cnt", kp.digit_cnt, 0);
        check("rst_key_err", kp.key_err, 0);
        check("rst_timeout", kp.timeout, 0);
        rst = 1'b1;

        // Balance query, keys ignored while issued, then release
        seq = '{1, 11, 1, 2, 3, 4, 11, 3, 11};
        send_seq(seq);
        step(1'b1, 5, 1'b0);
        step(1'b1, 13, 1'b0);
        step(1'b1, 12, 1'b0);
        hold(3, 1'b1);

        // Deposit with a stalled consumer
        seq = '{1, 0, 11, 7, 1, 2, 3, 11, 5, 11, 1, 0, 0, 0, 11};
        send_seq(seq);
        hold(5, 1'b0);
        hold(3, 1'b1);

        // Validation: bad account, short PIN, fifth digit, bad op, illegal codes
        seq = '{1, 1, 11, 11, 5, 11, 1, 2, 3, 11, 4, 5, 11, 13, 14, 15, 9, 11, 8, 11, 12};
        send_seq(seq);

        // Change PIN with CLEAR
        seq = '{2, 11, 2, 3, 4, 5, 11, 2, 11, 9, 10, 6, 7, 8, 9, 11};
        send_seq(seq);
        hold(2, 1'b1);

        // Cancel during a withdraw amount
        seq = '{3, 11, 1, 1, 1, 1, 11, 4, 11, 5, 12};
        send_seq(seq);

        // Amount width: nine nines, tenth digit rejected, then zero amount rejected
        seq = '{1, 11, 0, 0, 0, 0, 11, 4, 11, 0, 11, 10};
        repeat (10) seq.push_back(9);
        seq.push_back(11);
        send_seq(seq);
        hold(2, 1'b1);

        for (int t = 0; t < 60; t++) rand_txn();

        hold(3, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        check("req_queue_left", rq_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/atm_keypad_entry.md
Name: atm_keypad_entry

Overview:
Upstream front end for the ATM transaction core. Collects decimal keypad strokes into the account number, PIN, operation code, amount and new-PIN fields that the core consumes. Presents one complete transaction request with a valid/ready handshake. Validates field lengths and ranges, supports clear/cancel, and aborts stale sessions on inactivity.

Parameters:
AMT_DIGITS, 9, maximum amount digits; 9 guarantees the value fits in 32 bits.
OP_WITHDRAW, 4, operation code that requires an amount field.
OP_DEPOSIT, 5, operation code that requires an amount field.
OP_CHPIN, 2, operation code that requires a new-PIN field.
TIMEOUT_CYCLES, 1000000, idle cycles before a session abort (only with the optional feature).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
key_valid  in  1  one-cycle strobe; key_code is valid
key_code  in  4  0-9 digit; 4'hA CLEAR; 4'hB ENTER; 4'hC CANCEL; 4'hD-F illegal
req_ready  in  1  ATM core accepts the request
req_valid  out  1  request fields complete and stable
acc_num  out  4  account number, 1..10
pin  out  16  entered PIN, binary value of 4 decimal digits
operation  out  3  operation code, 0..7
amount  out  32  binary amount; 0 when the operation does not use it
newPin  out  16  new PIN; 0 unless operation==OP_CHPIN
entry_state  out  3  current FSM state
digit_cnt  out  4  digits entered in the current field
key_err  out  1  one-cycle pulse on a rejected key or ENTER
timeout  out  1  one-cycle pulse on inactivity abort

Behaviour:
- Reset (rst=0, async): state S_ACC; all outputs 0; internal accumulator and counters 0.
- States: S_ACC=0, S_PIN=1, S_OP=2, S_AMT=3, S_NPIN=4, S_ISSUE=5. Codes 6-7 are unused and return to S_ACC.
- Digit keys: accumulator <= accumulator*10 + digit, and digit_cnt increments. This is computed in 32 bits and registered on the same clock edge as key_valid.
- Per-field digit limits: ACC 2, PIN 4, OP 1, AMT AMT_DIGITS, NPIN 4. A digit beyond the limit is dropped and key_err pulses.
- CLEAR: zeroes the current accumulator and digit_cnt; the state is unchanged.
- CANCEL in any state except S_ISSUE: go to S_ACC and clear all fields. CANCEL in S_ISSUE is ignored because the request is committed.
- Illegal codes 4'hD-F: ignored and key_err pulses.
- ENTER validation per state:
  - S_ACC: value must be 1..10. Otherwise key_err and the field clears.
  - S_PIN: digit_cnt must equal 4. Leading zeros count as digits.
  - S_OP: exactly 1 digit, value 0..7.
  - S_AMT: at least 1 digit and a nonzero value.
  - S_NPIN: digit_cnt must equal 4.
  - On success: latch the value into its output, reset the accumulator and digit_cnt, advance to the next state.
- Transitions:
  - S_ACC -> S_PIN -> S_OP.
  - From S_OP: to S_AMT if op is OP_WITHDRAW or OP_DEPOSIT; to S_NPIN if op is OP_CHPIN; otherwise to S_ISSUE.
  - S_AMT -> S_ISSUE. S_NPIN -> S_ISSUE.
- Latency: req_valid rises on the cycle after the accepted final ENTER.
- Handshake:
  - req_valid holds and all fields stay stable until a cycle with req_valid & req_ready.
  - On that cycle the FSM goes to S_ACC and clears all fields on the next edge, so req_valid drops 1 cycle after the handshake.
  - req_ready while req_valid is low has no effect.
- Keys in S_ISSUE are ignored, with no key_err.
- An ENTER with an empty field pulses key_err, except where that case is covered above.

Optional Feature:
Macro KEYPAD_TIMEOUT_EN.
- Defined:
  - A 20-bit idle counter reloads on every key_valid and counts down in states S_PIN..S_NPIN.
  - On reaching 0, timeout pulses for 1 cycle and the FSM goes to S_ACC with all fields cleared.
  - key_valid on the expiry cycle wins: the key is processed and the counter reloads.
  - The counter does not run in S_ACC or S_ISSUE.
- Undefined: no counter is present and the timeout output is tied to 0.

Test Plan:
- Reset and balance query: rst low then high; keys 1,ENTER,1,2,3,4,ENTER,3,ENTER -> entry_state 0 after reset, then req_valid=1 with acc_num=1, pin=1234, operation=3, amount=0. Hold req_ready=1 -> req_valid=0 one cycle later.
- Deposit: keys 1,0,ENTER,7,1,2,3,ENTER,5,ENTER,1,0,0,0,ENTER -> acc_num=10, pin=7123, operation=5, amount=1000. req_ready held 0 for 5 cycles -> fields stay stable.
- Validation: acc 1,1,ENTER -> key_err, state S_ACC. PIN 1,2,3,ENTER -> key_err, state S_PIN. Fifth PIN digit -> key_err, pin digits unchanged.
- Change PIN with CLEAR: acc 2, pin 2345, op 2, keys 9,CLEAR,6,7,8,9,ENTER -> newPin=6789, amount=0. CANCEL during S_AMT of a withdraw -> S_ACC with all fields 0.
- Amount width: withdraw with 9 nines -> amount=999999999; a tenth digit -> key_err, value unchanged.
- With KEYPAD_TIMEOUT_EN and TIMEOUT_CYCLES=16: no key for 16 cycles in S_PIN -> timeout pulse and S_ACC. A key on the expiry cycle -> no abort.
